rsa_stream_if: RTL

Word-serial host front end for the RSA-4096 exponentiation core. It accepts 64-bit words on a valid/ready input stream and assembles them into the 4096-bit `message`, `exponent` and `modulus` operands. It then launches the core with a one-cycle `go` pulse and waits for `done`. Finally it captures the 4096-bit `cypher` and returns it as 64 words on a valid/ready output stream. It sits between the system bus/DMA and the core's parallel `go`/`done` port set.

---
 rtl/rsa_stream_if.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rsa_stream_if.sv
// rsa_stream_if
// Word-serial host front end for the RSA-4096 exponentiation core.
// It collects 3 x WORDS input words (message, then exponent, then modulus,
// least-significant word first) into parallel operand registers.
// It then pulses core_go, waits for core_done, and streams the captured
// cypher back out as WORDS words, least-significant first.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last   input word stream
//   m_valid/m_ready/m_data/m_last   output result stream
//   message/exponent/modulus        operands to the core (held during compute)
//   core_go/core_done/core_cypher   parallel core handshake and result
//   busy                  high from first accepted word to last result word
//   frame_err             one-cycle pulse when s_last arrives too early

module rsa_stream_if #(
  parameter int RSA_WIDTH  = 4096,
  parameter int DATA_WIDTH = 64,
  parameter int WORDS      = RSA_WIDTH / DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [RSA_WIDTH-1:0]  message,
  output logic [RSA_WIDTH-1:0]  exponent,
  output logic [RSA_WIDTH-1:0]  modulus,
  output logic                  core_go,
  input  logic                  core_done,
  input  logic [RSA_WIDTH-1:0]  core_cypher,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int CW = $clog2(WORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

  typedef enum logic [2:0] {
    LOAD_M,
    LOAD_E,
    LOAD_N,
    START,
    WAIT,
    DRAIN
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]        word_cnt;
  logic [1:0]           guard_cnt;
  logic [RSA_WIDTH-1:0] shreg;
  logic [31:0]          word_base;

  logic s_hs;
  logic m_hs;
  logic last_word;
  logic bad_last;
  logic guard_done;
  logic capture;

  // Handshake qualifiers and framing check. The only word allowed to carry
  // s_last is the final modulus word; anything earlier aborts the frame.
  assign s_hs       = s_valid && s_ready;
  assign m_hs       = m_valid && m_ready;
  assign last_word  = (word_cnt == LAST_IDX);
  assign bad_last   = s_hs && s_last && !((state == LOAD_N) && last_word);
  assign guard_done = (guard_cnt == 2'd2);
  // The core only clears a stale done after it sees go, so done is ignored
  // for the first two WAIT cycles.
  assign capture    = (state == WAIT) && guard_done && core_done;
  assign word_base  = 32'(word_cnt) * 32'(DATA_WIDTH);

  // Moore-style stream and core control outputs.
  assign s_ready = (state == LOAD_M) || (state == LOAD_E) || (state == LOAD_N);
  assign core_go = (state == START);
  assign m_valid = (state == DRAIN);
  assign m_last  = m_valid && last_word;
  assign m_data  = m_valid ? shreg[DATA_WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD_M;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD_M: begin
        if (bad_last)               state_next = LOAD_M;
        else if (s_hs && last_word) state_next = LOAD_E;
      end
      LOAD_E: begin
        if (bad_last)               state_next = LOAD_M;
        else if (s_hs && last_word) state_next = LOAD_N;
      end
      LOAD_N: begin
        if (bad_last)               state_next = LOAD_M;
        else if (s_hs && last_word) state_next = START;
      end
      START: state_next = WAIT;
      WAIT: begin
        if (capture) state_next = DRAIN;
      end
      DRAIN: begin
        if (m_hs && last_word) state_next = LOAD_M;
      end
      default: state_next = LOAD_M;
    endcase
  end

  // Datapath: operand assembly, guard counter, result shift register and
  // the shared word counter (input words while loading, output words while
  // draining). Operands are only written in the load states, so they stay
  // stable from START until the result has been drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      message   <= '0;
      exponent  <= '0;
      modulus   <= '0;
      shreg     <= '0;
      word_cnt  <= '0;
      guard_cnt <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= bad_last;

      if (bad_last) begin
        word_cnt <= '0;
        busy     <= 1'b0;
      end else if (s_hs) begin
        case (state)
          LOAD_M:  message[word_base +: DATA_WIDTH]  <= s_data;
          LOAD_E:  exponent[word_base +: DATA_WIDTH] <= s_data;
          default: modulus[word_base +: DATA_WIDTH]  <= s_data;
        endcase
        word_cnt <= last_word ? '0 : word_cnt + 1'b1;
        busy     <= 1'b1;
      end

      if (state == START) begin
        guard_cnt <= '0;
      end else if ((state == WAIT) && !guard_done) begin
        guard_cnt <= guard_cnt + 2'd1;
      end

      if (capture) begin
        shreg <= core_cypher;
      end

      if (m_hs) begin
        shreg    <= shreg >> DATA_WIDTH;
        word_cnt <= last_word ? '0 : word_cnt + 1'b1;
        if (last_word) begin
          busy <= 1'b0;
        end
      end
    end
  end

endmodule
